// File: rtl/i2c_transaction_sequencer.sv
// Sequences a byte-level I2C unit (start/stop/tx/rx commands) into complete
// START, address, N data bytes, STOP transactions, and generates its cycle tick.
module i2c_transaction_sequencer #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clkDiv,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [6:0]       reqAddr,
    input  logic             reqRead,
    input  logic [LEN_W-1:0] reqLen,
    input  logic [7:0]       wrData,
    input  logic             wrValid,
    output logic             wrReady,
    output logic [7:0]       rdData,
    output logic             rdValid,
    input  logic             rdReady,
    output logic             done,
    output logic             nackErr,
    output logic             busy,
    output logic             i2cCycleDone,
    output logic [1:0]       i2cCommand,
    output logic [7:0]       i2cTransmitData,
    output logic             i2cTransmitAck,
    output logic             i2cTransmitValid,
    input  logic             i2cTransmitReady,
    input  logic [7:0]       i2cReceiveData,
    input  logic             i2cReceiveAck,
    input  logic             i2cReceiveValid,
    input  logic             i2cBusy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_WR_FETCH,
        ST_WR,
        ST_RD,
        ST_RD_PUSH,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t           state;
    logic             waiting;
    logic [DIV_W-1:0] tick_cnt;
    logic [6:0]       addr_q;
    logic             read_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [7:0]       wr_byte;
    logic [7:0]       rx_data;
    logic             rx_ack;

    logic [1:0]       cmd_c;
    logic [7:0]       data_c;
    logic             ack_c;
    logic             cmd_state_c;
    logic             cmd_done_c;
    logic [LEN_W-1:0] count_inc_c;

    // Free-running cycle tick, period clkDiv+1
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt     <= '0;
            i2cCycleDone <= 1'b0;
        end else if (tick_cnt == '0) begin
            tick_cnt     <= clkDiv;
            i2cCycleDone <= 1'b1;
        end else begin
            tick_cnt     <= tick_cnt - DIV_W'(1);
            i2cCycleDone <= 1'b0;
        end
    end

    // Capture the unit's receive byte / slave ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data <= 8'h00;
            rx_ack  <= 1'b0;
        end else if (i2cReceiveValid) begin
            rx_data <= i2cReceiveData;
            rx_ack  <= i2cReceiveAck;
        end
    end

    // Command the current state presents to the unit
    always_comb begin
        cmd_c  = CMD_START;
        data_c = 8'h00;
        ack_c  = 1'b0;
        case (state)
            ST_ADDR: begin
                cmd_c  = CMD_WRITE;
                data_c = {addr_q, read_q};
            end
            ST_WR: begin
                cmd_c  = CMD_WRITE;
                data_c = wr_byte;
            end
            ST_RD: begin
                cmd_c  = CMD_READ;
                data_c = 8'hFF;
                ack_c  = (count == len_q - LEN_W'(1));
            end
            ST_STOP: cmd_c = CMD_STOP;
            default: cmd_c = CMD_START;
        endcase
    end

    assign cmd_state_c = state inside {ST_START, ST_ADDR, ST_WR, ST_RD, ST_STOP};
    assign cmd_done_c  = waiting && !i2cBusy;
    assign count_inc_c = count + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ST_IDLE;
            waiting          <= 1'b0;
            addr_q           <= 7'h00;
            read_q           <= 1'b0;
            len_q            <= '0;
            count            <= '0;
            wr_byte          <= 8'h00;
            reqReady         <= 1'b1;
            wrReady          <= 1'b0;
            rdData           <= 8'h00;
            rdValid          <= 1'b0;
            done             <= 1'b0;
            nackErr          <= 1'b0;
            busy             <= 1'b0;
            i2cCommand       <= 2'b00;
            i2cTransmitData  <= 8'h00;
            i2cTransmitAck   <= 1'b0;
            i2cTransmitValid <= 1'b0;
        end else begin
            wrReady <= 1'b0;
            done    <= 1'b0;

            // ISSUE until the unit takes the command, then WAIT for it to go idle
            if (cmd_state_c) begin
                if (!waiting) begin
                    if (!i2cTransmitValid) begin
                        i2cCommand       <= cmd_c;
                        i2cTransmitData  <= data_c;
                        i2cTransmitAck   <= ack_c;
                        i2cTransmitValid <= 1'b1;
                    end else if (i2cTransmitReady) begin
                        i2cTransmitValid <= 1'b0;
                        waiting          <= 1'b1;
                    end
                end else if (!i2cBusy) begin
                    waiting <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        addr_q   <= reqAddr;
                        read_q   <= reqRead;
                        len_q    <= reqLen;
                        count    <= '0;
                        nackErr  <= 1'b0;
                        reqReady <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (cmd_done_c) state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (cmd_done_c) begin
                        if (rx_ack) begin
                            nackErr <= 1'b1;
                            state   <= ST_STOP;
                        end else if (len_q == '0) begin
                            state <= ST_STOP;
                        end else if (read_q) begin
                            state <= ST_RD;
                        end else begin
                            state <= ST_WR_FETCH;
                        end
                    end
                end
                ST_WR_FETCH: begin
                    if (wrValid) begin
                        wr_byte <= wrData;
                        wrReady <= 1'b1;
                        state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (cmd_done_c) begin
                        if (rx_ack) begin
                            nackErr <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            count <= count_inc_c;
                            state <= (count_inc_c == len_q) ? ST_STOP : ST_WR_FETCH;
                        end
                    end
                end
                ST_RD: begin
                    if (cmd_done_c) begin
                        rdData  <= rx_data;
                        rdValid <= 1'b1;
                        state   <= ST_RD_PUSH;
                    end
                end
                ST_RD_PUSH: begin
                    if (rdReady) begin
                        rdValid <= 1'b0;
                        count   <= count_inc_c;
                        state   <= (count_inc_c == len_q) ? ST_STOP : ST_RD;
                    end
                end
                ST_STOP: begin
                    if (cmd_done_c) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    reqReady <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Bench for i2c_transaction_sequencer: byte-unit responder, host stream agents and
// a transaction-level reference model of the expected command/data sequence.
module tb_i2c_transaction_sequencer;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DIV_W-1:0] clkDiv;
    logic             reqValid;
    logic             reqReady;
    logic [6:0]       reqAddr;
    logic             reqRead;
    logic [LEN_W-1:0] reqLen;
    logic [7:0]       wrData;
    logic             wrValid;
    logic             wrReady;
    logic [7:0]       rdData;
    logic             rdValid;
    logic             rdReady;
    logic             done;
    logic             nackErr;
    logic             busy;
    logic             i2cCycleDone;
    logic [1:0]       i2cCommand;
    logic [7:0]       i2cTransmitData;
    logic             i2cTransmitAck;
    logic             i2cTransmitValid;
    logic             i2cTransmitReady;
    logic [7:0]       i2cReceiveData;
    logic             i2cReceiveAck;
    logic             i2cReceiveValid;
    logic             i2cBusy;

    always #5 clk = ~clk;

    i2c_transaction_sequencer #(.LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .clkDiv(clkDiv),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqRead(reqRead), .reqLen(reqLen),
        .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
        .done(done), .nackErr(nackErr), .busy(busy),
        .i2cCycleDone(i2cCycleDone), .i2cCommand(i2cCommand),
        .i2cTransmitData(i2cTransmitData), .i2cTransmitAck(i2cTransmitAck),
        .i2cTransmitValid(i2cTransmitValid), .i2cTransmitReady(i2cTransmitReady),
        .i2cReceiveData(i2cReceiveData), .i2cReceiveAck(i2cReceiveAck),
        .i2cReceiveValid(i2cReceiveValid), .i2cBusy(i2cBusy)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Command log entries are {cmd, data, ack}; data/ack normalised to 0 where unused
    logic [10:0] cmd_log[$];
    logic [10:0] exp_cmd[$];
    logic [7:0]  rd_log[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  wq[256];
    logic [7:0]  sq[256];
    int          exp_wr;
    logic        exp_nack;
    int          wr_pulses = 0;
    int          wr_idx = 0;
    int          rx_idx = 0;
    int          tx_cnt = 0;
    int          nack_idx = -1;
    int          done_cnt = 0;
    bit          wr_hold = 1'b0;
    bit          rd_hold = 1'b0;
    logic [1:0]  bfm_cmd;
    logic [7:0]  bfm_data;
    logic        bfm_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the transaction as the I2C rules describe it
    task automatic build_expected(input logic [6:0] addr, input logic read,
                                  input logic [7:0] len, input int nack);
        exp_cmd.delete();
        exp_rd.delete();
        exp_wr   = 0;
        exp_nack = 1'b0;
        exp_cmd.push_back({2'b00, 8'h00, 1'b0});
        exp_cmd.push_back({2'b10, addr, read, 1'b0});
        if (nack == 0) begin
            exp_nack = 1'b1;
        end else if (read) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_cmd.push_back({2'b11, 8'hFF, 1'(i == int'(len) - 1)});
                exp_rd.push_back(sq[i]);
            end
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                exp_cmd.push_back({2'b10, wq[i], 1'b0});
                exp_wr++;
                if (nack == i + 1) begin
                    exp_nack = 1'b1;
                    break;
                end
            end
        end
        exp_cmd.push_back({2'b01, 8'h00, 1'b0});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " reqReady"}, reqReady, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " nackErr"}, nackErr, 0);
        chk({tag, " wrReady"}, wrReady, 0);
        chk({tag, " rdValid"}, rdValid, 0);
        chk({tag, " rdData"}, rdData, 0);
        chk({tag, " cycleDone"}, i2cCycleDone, 0);
        chk({tag, " command"}, i2cCommand, 0);
        chk({tag, " txData"}, i2cTransmitData, 0);
        chk({tag, " txAck"}, i2cTransmitAck, 0);
        chk({tag, " txValid"}, i2cTransmitValid, 0);
    endtask

    task automatic start_txn(input logic [6:0] addr, input logic read,
                             input logic [7:0] len, input int nack);
        nack_idx = nack;
        build_expected(addr, read, len, nack);
        cmd_log.delete();
        rd_log.delete();
        wr_pulses = 0;
        wr_idx    = 0;
        rx_idx    = 0;
        tx_cnt    = 0;
        @(negedge clk);
        chk("reqReady idle", reqReady, 1);
        reqAddr  = addr;
        reqRead  = read;
        reqLen   = len;
        reqValid = 1'b1;
        @(negedge clk);
        chk("busy after accept", busy, 1);
        // A second request while busy must be ignored
        reqAddr = ~addr;
        reqRead = ~read;
        reqLen  = 8'd9;
        @(negedge clk);
        chk("reqReady while busy", reqReady, 0);
        reqValid = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        bit got = 1'b0;
        int n;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " done seen"}, 32'(got), 1);
        chk({tag, " nackErr"}, nackErr, 32'(exp_nack));
        @(negedge clk);
        chk({tag, " done width"}, done, 0);
        chk({tag, " nackErr sticky"}, nackErr, 32'(exp_nack));
        chk({tag, " reqReady back"}, reqReady, 1);
        repeat (4) @(negedge clk);
        chk({tag, " cmd count"}, cmd_log.size(), exp_cmd.size());
        n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s cmd[%0d]", tag, i), 32'(cmd_log[i]), 32'(exp_cmd[i]));
        chk({tag, " rd count"}, rd_log.size(), exp_rd.size());
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
        chk({tag, " wrReady pulses"}, wr_pulses, exp_wr);
    endtask

    // Byte-level unit responder: accepts on sight, stays busy a random while
    initial begin
        i2cTransmitReady = 1'b0;
        i2cBusy          = 1'b0;
        i2cReceiveValid  = 1'b0;
        i2cReceiveData   = 8'h00;
        i2cReceiveAck    = 1'b0;
        forever begin
            @(negedge clk);
            if (i2cTransmitValid === 1'b1) begin
                bfm_cmd  = i2cCommand;
                bfm_data = (bfm_cmd[1]) ? i2cTransmitData : 8'h00;
                bfm_ack  = (bfm_cmd == 2'b11) ? i2cTransmitAck : 1'b0;
                cmd_log.push_back({bfm_cmd, bfm_data, bfm_ack});
                i2cTransmitReady = 1'b1;
                i2cBusy          = 1'b1;
                @(negedge clk);
                i2cTransmitReady = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (bfm_cmd[1]) begin
                    if (bfm_cmd == 2'b10) begin
                        i2cReceiveAck  = (tx_cnt == nack_idx);
                        i2cReceiveData = 8'($urandom);
                        tx_cnt++;
                    end else begin
                        i2cReceiveAck  = 1'b0;
                        i2cReceiveData = sq[rx_idx % 256];
                        rx_idx++;
                    end
                    i2cReceiveValid = 1'b1;
                    @(negedge clk);
                    i2cReceiveValid = 1'b0;
                end
                @(negedge clk);
                i2cBusy = 1'b0;
            end
        end
    end

    // Host write-data source with random gaps
    initial begin
        wrValid = 1'b0;
        wrData  = 8'h00;
        forever begin
            @(negedge clk);
            if (wrReady === 1'b1) begin
                wr_pulses++;
                wr_idx++;
            end
            wrData  = wq[wr_idx % 256];
            wrValid = !wr_hold && ($urandom_range(0, 3) != 0);
        end
    end

    // Host read-data sink with random backpressure
    initial begin
        rdReady = 1'b0;
        forever begin
            @(negedge clk);
            if (rdValid === 1'b1 && !rd_hold && $urandom_range(0, 1) == 1) begin
                rdReady = 1'b1;
                rd_log.push_back(rdData);
            end else begin
                rdReady = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        int  a, r, l, nk, d0;
        bit  seen;
        clkDiv   = '0;
        reqValid = 1'b0;
        reqAddr  = 7'h00;
        reqRead  = 1'b0;
        reqLen   = '0;
        for (int i = 0; i < 256; i++) begin
            wq[i] = 8'($urandom);
            sq[i] = 8'($urandom);
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b1;

        // clkDiv = 0: tick every cycle
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("tick div0", i2cCycleDone, 1);
            @(negedge clk);
        end

        // clkDiv = 3: tick every fourth cycle
        clkDiv = 16'd3;
        repeat (10) @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (i2cCycleDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("tick sync", 32'(seen), 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("tick div3 k%0d", k), i2cCycleDone, 32'(k % 4 == 0));
        end

        // Two-byte write, all acked
        wq[0] = 8'hA5;
        wq[1] = 8'h3C;
        start_txn(7'h50, 1'b0, 8'd2, -1);
        finish_txn("write2");

        // Three-byte read with the host stalling the first byte
        sq[0] = 8'h11;
        sq[1] = 8'h22;
        sq[2] = 8'h33;
        rd_hold = 1'b1;
        start_txn(7'h68, 1'b1, 8'd3, -1);
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (rdValid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rd stall reached", 32'(seen), 1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("rd stall valid", rdValid, 1);
            chk("rd stall data", rdData, 8'h11);
        end
        rd_hold = 1'b0;
        finish_txn("read3");

        // Address NACK
        start_txn(7'h27, 1'b0, 8'd4, 0);
        finish_txn("addr nack");

        // Address-only probe
        start_txn(7'h3C, 1'b1, 8'd0, -1);
        finish_txn("probe");

        // Data NACK on the second byte
        start_txn(7'h1A, 1'b0, 8'd4, 2);
        finish_txn("data nack");

        // Write-data starvation holds the transaction
        wr_hold = 1'b1;
        start_txn(7'h12, 1'b0, 8'd1, -1);
        for (int k = 0; k < 200 && cmd_log.size() < 2; k++) @(negedge clk);
        repeat (50) @(negedge clk);
        chk("wr stall cmds", cmd_log.size(), 2);
        chk("wr stall pulses", wr_pulses, 0);
        chk("wr stall txValid", i2cTransmitValid, 0);
        chk("wr stall busy", busy, 1);
        wr_hold = 1'b0;
        finish_txn("wr stall");

        // Full-length write
        for (int i = 0; i < 256; i++) wq[i] = 8'($urandom);
        start_txn(7'($urandom_range(0, 127)), 1'b0, 8'd255, -1);
        finish_txn("write255");

        // Random transactions
        for (int t = 0; t < 8; t++) begin
            a  = $urandom_range(0, 127);
            r  = $urandom_range(0, 1);
            l  = $urandom_range(0, 6);
            nk = -1;
            if ($urandom_range(0, 2) == 0) nk = (r == 1) ? 0 : $urandom_range(0, l);
            for (int i = 0; i < 256; i++) begin
                wq[i] = 8'($urandom);
                sq[i] = 8'($urandom);
            end
            start_txn(7'(a), 1'(r), 8'(l), nk);
            finish_txn($sformatf("rand%0d", t));
        end

        // Reset in the middle of a read aborts without done
        start_txn(7'h55, 1'b1, 8'd3, -1);
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (i2cTransmitValid === 1'b1 && i2cCommand === 2'b11) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached RD", 32'(seen), 1);
        d0 = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid-rd reset");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("no done after reset", done_cnt, d0);
        for (int i = 0; i < 256; i++) sq[i] = 8'($urandom);
        start_txn(7'h2B, 1'b1, 8'd2, -1);
        finish_txn("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
